hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB registers).
- Keeps a shadow pipeline of destination tags for EX, MEM and WB.
- Detects load-use hazards, produces forwarding selects for the three ID source operands, sequences taken-branch flushes and data-memory wait freezes.
- Sits beside the decode stage. Drives the PC enable, the IF/ID load enable and reset, the ID/EXE bubble, and the downstream hold.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_fwd_sel.sv | 52 +++++
 rtl/hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the forwarding-select encoding and the per-stage destination tag
// carried by the shadow pipeline (EX, MEM, WB).
package hazard_pkg;

    localparam int unsigned TAG_REG_W = 4;
    localparam int unsigned FWD_W     = 2;

    typedef logic [FWD_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;

    // Destination tag of the instruction occupying one downstream stage.
    typedef struct packed {
        logic                 v;
        logic [TAG_REG_W-1:0] rd;
        logic                 wr;
        logic                 ld;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one ID source operand.
// Compares one source index against the EX, MEM and WB tags; the youngest
// producer wins, except that a load in EX cannot forward and instead raises
// ex_ld_hit_o so the top can insert a load-use bubble.
// Ports:
//   src_i        source register index
//   use_i        source is actually read
//   ex_i/mem_i/wb_i  stage tags
//   sel_o        operand select (RF/EX/MEM/WB)
//   ex_ld_hit_o  source depends on a load currently in EX
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned PC_REG = 15
) (
    input  logic [TAG_REG_W-1:0] src_i,
    input  logic                 use_i,
    input  stage_tag_t           ex_i,
    input  stage_tag_t           mem_i,
    input  stage_tag_t           wb_i,
    output fwd_sel_t             sel_o,
    output logic                 ex_ld_hit_o
);

    logic src_ok;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic unused_ld;

    // The PC register is never produced through the pipeline, so never forwarded.
    assign src_ok  = use_i & (src_i != TAG_REG_W'(PC_REG));
    assign ex_hit  = src_ok & ex_i.v  & ex_i.wr  & (ex_i.rd  == src_i);
    assign mem_hit = src_ok & mem_i.v & mem_i.wr & (mem_i.rd == src_i);
    assign wb_hit  = src_ok & wb_i.v  & wb_i.wr  & (wb_i.rd  == src_i);

    assign unused_ld = mem_i.ld ^ wb_i.ld;

    // Youngest producer first; load data is not available until MEM.
    always_comb begin
        sel_o       = FWD_RF;
        ex_ld_hit_o = ex_hit & ex_i.ld;
        if (ex_hit & ~ex_i.ld) begin
            sel_o = FWD_EX;
        end else if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Tracks destination tags for EX/MEM/WB, detects load-use hazards, produces
// operand forwarding selects, sequences taken-branch flushes and data-memory
// wait freezes. Control outputs are combinational from the tags and ID inputs.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   id_*                  decode-stage instruction fields
//   branch_taken          taken branch resolved in ID
//   mem_busy              data memory not ready this cycle
//   pc_le, if_id_le       PC / IF-ID load enables
//   if_id_flush           IF/ID reset request
//   id_nop                bubble into ID/EXE
//   pipe_hold             hold ID/EXE, EXE/MEM, MEM/WB
//   fwd_rn/rm/rs          operand selects (00 RF, 01 EX, 10 MEM, 11 WB)
//   stall_cnt, flush_cnt  performance counters (optional)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W  = TAG_REG_W,
    parameter int unsigned PC_REG = 15
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rs,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rf_en,
    input  logic             id_load,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             if_id_flush,
    output logic             id_nop,
    output logic             pipe_hold,
    output logic [1:0]       fwd_rn,
    output logic [1:0]       fwd_rm,
    output logic [1:0]       fwd_rs
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    stage_tag_t ex_q, mem_q, wb_q;
    stage_tag_t ex_d, mem_d, wb_d;

    fwd_sel_t sel_rn, sel_rm, sel_rs;
    logic     ld_hit_rn, ld_hit_rm, ld_hit_rs;
    logic     stall_c;
    logic     br_flush_c;

    hazard_fwd_sel #(.PC_REG(PC_REG)) u_sel_rn (
        .src_i       (TAG_REG_W'(id_rn)),
        .use_i       (id_use_rn),
        .ex_i        (ex_q),
        .mem_i       (mem_q),
        .wb_i        (wb_q),
        .sel_o       (sel_rn),
        .ex_ld_hit_o (ld_hit_rn)
    );

    hazard_fwd_sel #(.PC_REG(PC_REG)) u_sel_rm (
        .src_i       (TAG_REG_W'(id_rm)),
        .use_i       (id_use_rm),
        .ex_i        (ex_q),
        .mem_i       (mem_q),
        .wb_i        (wb_q),
        .sel_o       (sel_rm),
        .ex_ld_hit_o (ld_hit_rm)
    );

    hazard_fwd_sel #(.PC_REG(PC_REG)) u_sel_rs (
        .src_i       (TAG_REG_W'(id_rs)),
        .use_i       (id_use_rs),
        .ex_i        (ex_q),
        .mem_i       (mem_q),
        .wb_i        (wb_q),
        .sel_o       (sel_rs),
        .ex_ld_hit_o (ld_hit_rs)
    );

    // Load-use hazard; a stall suppresses any branch resolved in the same cycle.
    assign stall_c    = id_valid & (ld_hit_rn | ld_hit_rm | ld_hit_rs);
    assign br_flush_c = branch_taken & id_valid & ~stall_c;

    // Shadow pipeline advance; frozen while data memory is busy.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_busy) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (stall_c || br_flush_c) begin
                ex_d = TAG_BUBBLE;
            end else begin
                ex_d.v  = id_valid;
                ex_d.rd = TAG_REG_W'(id_rd);
                ex_d.wr = id_rf_en;
                ex_d.ld = id_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= TAG_BUBBLE;
            mem_q <= TAG_BUBBLE;
            wb_q  <= TAG_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Pipeline control, priority reset > mem_busy > stall > branch.
    always_comb begin
        pc_le       = 1'b1;
        if_id_le    = 1'b1;
        if_id_flush = 1'b0;
        id_nop      = 1'b0;
        pipe_hold   = 1'b0;
        fwd_rn      = stall_c ? FWD_RF : sel_rn;
        fwd_rm      = stall_c ? FWD_RF : sel_rm;
        fwd_rs      = stall_c ? FWD_RF : sel_rs;
        if (reset) begin
            // IF/ID only clears when loaded, hence if_id_le stays high.
            pc_le       = 1'b0;
            if_id_flush = 1'b1;
            id_nop      = 1'b1;
            fwd_rn      = FWD_RF;
            fwd_rm      = FWD_RF;
            fwd_rs      = FWD_RF;
        end else if (mem_busy) begin
            pc_le     = 1'b0;
            if_id_le  = 1'b0;
            pipe_hold = 1'b1;
        end else if (stall_c) begin
            pc_le    = 1'b0;
            if_id_le = 1'b0;
            id_nop   = 1'b1;
        end else if (br_flush_c) begin
            if_id_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters; only cycles where the event takes effect count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c && !mem_busy && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (br_flush_c && !mem_busy && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed and random
// decode-stage traffic and pushes the expected response from an
// instruction-history reference model; a monitor pops and compares.
module tb_hazard_ctrl;

    localparam int CNT_W_TB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [3:0] id_rn, id_rm, id_rs, id_rd;
    logic       id_use_rn, id_use_rm, id_use_rs;
    logic       id_rf_en, id_load, branch_taken, mem_busy;
    logic       pc_le, if_id_le, if_id_flush, id_nop, pipe_hold;
    logic [1:0] fwd_rn, fwd_rm, fwd_rs;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W_TB-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_W  (4),
        .PC_REG (15)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .CNT_W  (CNT_W_TB)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rs        (id_rs),
        .id_use_rn    (id_use_rn),
        .id_use_rm    (id_use_rm),
        .id_use_rs    (id_use_rs),
        .id_rd        (id_rd),
        .id_rf_en     (id_rf_en),
        .id_load      (id_load),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_le        (pc_le),
        .if_id_le     (if_id_le),
        .if_id_flush  (if_id_flush),
        .id_nop       (id_nop),
        .pipe_hold    (pipe_hold),
        .fwd_rn       (fwd_rn),
        .fwd_rm       (fwd_rm),
        .fwd_rs       (fwd_rs)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [3:0] rn;
        logic       urn;
        logic [3:0] rm;
        logic       urm;
        logic [3:0] rs;
        logic       urs;
        logic [3:0] rd;
        logic       rf;
        logic       ld;
        logic       br;
        logic       busy;
    } drv_t;

    typedef struct {
        int pc_le, if_id_le, flush, nop, hold;
        int frn, frm, frs;
        int scnt, fcnt;
    } exp_t;

    // Instruction history: index 0 is the instruction in EX, 1 in MEM, 2 in WB.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } ins_t;

    ins_t pipe[$];
    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   m_scnt = 0;
    int   m_fcnt = 0;
    int   cnt_max = (1 << CNT_W_TB) - 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit load_use(input int src, input bit use_);
        return use_ && src != 15 && pipe[0].v && pipe[0].wr && pipe[0].ld && pipe[0].rd == src;
    endfunction

    // Youngest writer of src; a load in EX cannot supply its value yet.
    function automatic int fwd_of(input int src, input bit use_);
        if (!use_ || src == 15) return 0;
        for (int k = 0; k < 3; k++) begin
            if (pipe[k].v && pipe[k].wr && pipe[k].rd == src) begin
                if (!(k == 0 && pipe[0].ld)) return k + 1;
            end
        end
        return 0;
    endfunction

    function automatic drv_t mk(input bit valid, input int rn, input bit urn, input int rm,
                                input bit urm, input int rd, input bit rf, input bit ld,
                                input bit br, input bit busy);
        drv_t d;
        d = '0;
        d.valid = valid; d.rn = 4'(rn); d.urn = urn; d.rm = 4'(rm); d.urm = urm;
        d.rs = 4'd0; d.urs = 1'b0; d.rd = 4'(rd); d.rf = rf; d.ld = ld;
        d.br = br; d.busy = busy;
        return d;
    endfunction

    task automatic step(input drv_t d);
        exp_t e;
        bit   st, flushing;
        ins_t n;
        @(negedge clk);
        reset = d.rst; id_valid = d.valid;
        id_rn = d.rn; id_rm = d.rm; id_rs = d.rs;
        id_use_rn = d.urn; id_use_rm = d.urm; id_use_rs = d.urs;
        id_rd = d.rd; id_rf_en = d.rf; id_load = d.ld;
        branch_taken = d.br; mem_busy = d.busy;

        st = d.valid && (load_use(int'(d.rn), d.urn) || load_use(int'(d.rm), d.urm) ||
                         load_use(int'(d.rs), d.urs));
        flushing = d.br && d.valid && !st;
        e.frn = st ? 0 : fwd_of(int'(d.rn), d.urn);
        e.frm = st ? 0 : fwd_of(int'(d.rm), d.urm);
        e.frs = st ? 0 : fwd_of(int'(d.rs), d.urs);
        e.hold = 0; e.flush = 0; e.nop = 0; e.pc_le = 1; e.if_id_le = 1;
        if (d.rst) begin
            e.pc_le = 0; e.flush = 1; e.nop = 1;
            e.frn = 0; e.frm = 0; e.frs = 0;
        end else if (d.busy) begin
            e.pc_le = 0; e.if_id_le = 0; e.hold = 1;
        end else if (st) begin
            e.pc_le = 0; e.if_id_le = 0; e.nop = 1;
        end else if (flushing) begin
            e.flush = 1;
        end
        e.scnt = m_scnt; e.fcnt = m_fcnt;
        expq.push_back(e);

        if (d.rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
            m_scnt = 0; m_fcnt = 0;
        end else if (!d.busy) begin
            if (st && m_scnt < cnt_max) m_scnt++;
            if (flushing && m_fcnt < cnt_max) m_fcnt++;
            if (st || flushing) n = '{0, 0, 0, 0};
            else n = '{d.valid, int'(d.rd), d.rf, d.ld};
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
    endtask

    // Monitor: outputs are valid every cycle, compared mid-low-phase.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("pc_le", 32'(pc_le), 32'(e.pc_le));
            chk("if_id_le", 32'(if_id_le), 32'(e.if_id_le));
            chk("if_id_flush", 32'(if_id_flush), 32'(e.flush));
            chk("id_nop", 32'(id_nop), 32'(e.nop));
            chk("pipe_hold", 32'(pipe_hold), 32'(e.hold));
            chk("fwd_rn", 32'(fwd_rn), 32'(e.frn));
            chk("fwd_rm", 32'(fwd_rm), 32'(e.frm));
            chk("fwd_rs", 32'(fwd_rs), 32'(e.frs));
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
            chk("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int rreg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 15 : r;
    endfunction

    initial begin
        drv_t d, idle, rst_d;
        for (int k = 0; k < 3; k++) pipe.push_back('{0, 0, 0, 0});
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_d = idle; rst_d.rst = 1'b1;
        reset = 1'b1; id_valid = 0; id_rn = 0; id_rm = 0; id_rs = 0; id_rd = 0;
        id_use_rn = 0; id_use_rm = 0; id_use_rs = 0; id_rf_en = 0; id_load = 0;
        branch_taken = 0; mem_busy = 0;
        @(posedge clk);

        // Reset held two cycles.
        repeat (2) begin
            step(rst_d); #3;
            chk("rst_pc_le", 32'(pc_le), 32'd0);
            chk("rst_if_id_le", 32'(if_id_le), 32'd1);
            chk("rst_flush", 32'(if_id_flush), 32'd1);
            chk("rst_nop", 32'(id_nop), 32'd1);
        end
        step(idle); #3;
        chk("post_rst_pc_le", 32'(pc_le), 32'd1);
        chk("post_rst_fwd", 32'({fwd_rn, fwd_rm, fwd_rs}), 32'd0);

        // ALU producer r3, dependents at EX, MEM, WB distance.
        step(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        step(mk(1, 3, 1, 0, 0, 6, 1, 0, 0, 0)); #3;
        chk("alu_fwd_ex", 32'(fwd_rn), 32'd1);
        step(mk(1, 0, 0, 3, 1, 7, 1, 0, 0, 0)); #3;
        chk("alu_fwd_mem", 32'(fwd_rm), 32'd2);
        step(mk(1, 3, 1, 0, 0, 8, 0, 0, 0, 0)); #3;
        chk("alu_fwd_wb", 32'(fwd_rn), 32'd3);

        // Load-use: one bubble then MEM forwarding.
        step(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0));
        step(mk(1, 0, 0, 2, 1, 9, 1, 0, 0, 0)); #3;
        chk("lu_stall", 32'({pc_le, if_id_le, id_nop}), 32'b001);
        step(mk(1, 0, 0, 2, 1, 9, 1, 0, 0, 0)); #3;
        chk("lu_fwd_mem", 32'(fwd_rm), 32'd2);
        chk("lu_no_stall", 32'(pc_le), 32'd1);

        // Branch alone, then branch coinciding with a load-use stall.
        repeat (3) step(idle);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); #3;
        chk("br_flush", 32'({if_id_flush, pc_le}), 32'b11);
        step(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0));
        step(mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 0)); #3;
        chk("br_stall_noflush", 32'({if_id_flush, pc_le}), 32'b00);
        step(mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 0)); #3;
        chk("br_after_stall", 32'(if_id_flush), 32'd1);

        // Memory wait with pending EX write to r5.
        step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0));
        repeat (3) begin
            step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 1)); #3;
            chk("busy_hold", 32'({pipe_hold, pc_le}), 32'b10);
            chk("busy_fwd", 32'(fwd_rn), 32'd1);
        end
        step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0)); #3;
        chk("busy_release_fwd", 32'(fwd_rn), 32'd1);
        step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0)); #3;
        chk("busy_advance_once", 32'(fwd_rn), 32'd2);

        // PC register is never forwarded.
        step(mk(1, 0, 0, 0, 0, 15, 1, 0, 0, 0));
        step(mk(1, 15, 1, 15, 1, 0, 0, 0, 0, 0)); #3;
        chk("pc_no_fwd", 32'({fwd_rn, fwd_rm}), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
        step(rst_d);
        repeat (3) begin
            step(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0));
            step(mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0));
            step(mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0));
        end
        step(idle); #3;
        chk("stall_cnt_3", 32'(stall_cnt), 32'd3);
        repeat ((1 << CNT_W_TB) + 5) begin
            step(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0));
            step(mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0));
            step(mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0));
        end
        step(idle); #3;
        chk("stall_cnt_sat", 32'(stall_cnt), 32'(cnt_max));
`endif

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            d = '0;
            d.rst   = ($urandom_range(0, 99) == 0);
            d.valid = ($urandom_range(0, 7) != 0);
            d.rn = 4'(rreg()); d.rm = 4'(rreg()); d.rs = 4'(rreg()); d.rd = 4'(rreg());
            d.urn = ($urandom_range(0, 3) != 0);
            d.urm = ($urandom_range(0, 1) != 0);
            d.urs = ($urandom_range(0, 3) == 0);
            d.rf  = ($urandom_range(0, 3) != 0);
            d.ld  = ($urandom_range(0, 2) == 0);
            d.br  = ($urandom_range(0, 5) == 0);
            d.busy = ($urandom_range(0, 5) == 0);
            step(d);
        end

        @(negedge clk); #4;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
